// File: rtl/rgmii_rx_frame.sv
// RGMII receive framer: preamble/SFD hunt, FCS stripping via a 5-byte delay line, length/error
// qualification and saturating frame counters. Define RX_CRC_CHECK_EN to add the CRC-32 residue check.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for rx_dv with a preamble byte
// PREAMBLE | inside the 0x55 run, waiting for the 0xD5 SFD
// DATA     | frame body; bytes pass through the 5-byte delay line
// DROP     | discarding the rest of a rejected or truncated frame
module rgmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  rx_ctl,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam int          DEPTH = 5;
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  dline [DEPTH];
    logic [2:0]  fill;
    logic        full;
    logic [10:0] len;
    logic        er_seen;
    logic        sof_pending;
    logic        crc_bad;
    logic        emit;
    logic        emit_eof;
    logic        emit_err;
    logic        short_bad;

    assign rx_dv = rx_ctl[1];
    assign rx_er = rx_ctl[1] ^ rx_ctl[0];
    assign full  = (fill == 3'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_dv) begin
                    state_nxt = (rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx_dv) begin
                    state_nxt = S_IDLE;
                end else if (rx_data == 8'hD5) begin
                    state_nxt = S_DATA;
                end else if (rx_data != 8'h55) begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!rx_dv) begin
                    state_nxt = S_IDLE;
                end else if (len == MAX_L) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!rx_dv) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decides what the delay line releases this cycle; results are registered below.
    always_comb begin
        emit      = 1'b0;
        emit_eof  = 1'b0;
        emit_err  = 1'b0;
        short_bad = 1'b0;
        if (state == S_DATA) begin
            if (rx_dv) begin
                if (len == MAX_L) begin
                    if (full) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                        emit_err = 1'b1;
                    end else begin
                        short_bad = 1'b1;
                    end
                end else if (full) begin
                    emit = 1'b1;
                end
            end else begin
                if (full) begin
                    emit     = 1'b1;
                    emit_eof = 1'b1;
                    emit_err = er_seen | (len < MIN_L) | crc_bad;
                end else begin
                    short_bad = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill        <= '0;
            len         <= '0;
            er_seen     <= 1'b0;
            sof_pending <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                dline[i] <= 8'h00;
            end
        end else if (state != S_DATA) begin
            fill        <= '0;
            len         <= '0;
            er_seen     <= 1'b0;
            sof_pending <= 1'b1;
        end else if (rx_dv) begin
            dline[0] <= rx_data;
            for (int i = 1; i < DEPTH; i++) begin
                dline[i] <= dline[i-1];
            end
            if (!full) begin
                fill <= fill + 3'd1;
            end
            len <= len + 11'd1;
            if (rx_er) begin
                er_seen <= 1'b1;
            end
            if (emit) begin
                sof_pending <= 1'b0;
            end
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 32'hFFFF_FFFF;
        end else if (state != S_DATA) begin
            crc <= 32'hFFFF_FFFF;
        end else if (rx_dv) begin
            crc <= crc_byte(crc, rx_data);
        end
    end

    // Register is kept LSB-first; 0xDEBB20E3 is the bit-reversed form of residue 0xC704DD7B.
    assign crc_bad = (crc != 32'hDEBB_20E3);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_err    <= 1'b0;
            frames_ok  <= 16'h0000;
            frames_bad <= 16'h0000;
        end else begin
            out_valid <= emit;
            out_sof   <= emit & sof_pending;
            out_eof   <= emit & emit_eof;
            out_err   <= emit & emit_eof & emit_err;
            if (emit) begin
                out_data <= dline[DEPTH-1];
            end
            if (emit && emit_eof && !emit_err && frames_ok != 16'hFFFF) begin
                frames_ok <= frames_ok + 16'd1;
            end
            if (((emit && emit_eof && emit_err) || short_bad) && frames_bad != 16'hFFFF) begin
                frames_bad <= frames_bad + 16'd1;
            end
        end
    end

endmodule

// File: doc/rgmii_rx_frame.md
RGMII_RX_FRAME -- requirements
Module: rgmii_rx_frame

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum good frame length in bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum good frame length in bytes after SFD, FCS included.
REQ-003 SHALL have ports `clk` (in, 1, receive byte clock) and `reset_n` (in, 1, asynchronous active-low reset), listed first.
REQ-004 SHALL have port `rx_data` (in, 8): demultiplexed RGMII byte; [3:0] is the first nibble on the wire.
REQ-005 SHALL have port `rx_ctl` (in, 2): rx_dv = rx_ctl[1]; rx_er = rx_ctl[1] XOR rx_ctl[0].
REQ-006 SHALL have ports `out_data` (out, 8), `out_valid` (out, 1), `out_sof` (out, 1), `out_eof` (out, 1) and `out_err` (out, 1); out_err is meaningful only with out_eof.
REQ-007 SHALL have ports `frames_ok` (out, 16) and `frames_bad` (out, 16): saturating frame counters.

Function
REQ-008 SHALL implement states IDLE, PREAMBLE, DATA and DROP, all transitions sampled on the `clk` rising edge.
REQ-009 In IDLE, a cycle with rx_dv=1 and byte 0x55 SHALL go to PREAMBLE; rx_dv=1 with any other byte SHALL go to DROP.
REQ-010 In PREAMBLE, byte 0x55 SHALL stay, byte 0xD5 SHALL go to DATA, any other byte SHALL go to DROP, and rx_dv=0 SHALL go to IDLE without counting.
REQ-011 In DATA, each rx_dv=1 byte SHALL enter a 5-entry delay line and increment an 11-bit length counter.
REQ-012 When the delay line is full, the oldest byte SHALL be emitted on out_data with out_valid=1 one cycle after the arriving byte.
REQ-013 out_sof SHALL be 1 on the first emitted byte of a frame.
REQ-014 The first rx_dv=0 cycle in DATA SHALL emit the oldest delay-line byte (the last payload byte) one cycle later with out_eof=1, discard the remaining 4 (FCS) bytes, and go to IDLE.
REQ-015 A frame with fewer than 5 bytes after SFD SHALL emit nothing and SHALL increment frames_bad.
REQ-016 out_err SHALL be 1 at eof if any of the following holds: rx_er was seen in DATA, length < MIN_LEN, or the CRC failed (REQ-023).
REQ-017 If the length would exceed MAX_LEN, the oldest byte SHALL be emitted with out_eof=1 and out_err=1, and the state SHALL go to DROP.
REQ-018 DROP SHALL emit nothing and SHALL go to IDLE on the first rx_dv=0 cycle; DROP reached from IDLE or PREAMBLE SHALL NOT count.
REQ-019 Each out_eof with out_err=0 SHALL increment frames_ok; each out_eof with out_err=1, and each case of REQ-015, SHALL increment frames_bad.
REQ-020 Both counters SHALL hold at 0xFFFF.
REQ-021 out_valid SHALL be 1 for at most one cycle per received byte; there is no backpressure.

Reset
REQ-022 reset_n low SHALL asynchronously force state IDLE, delay line empty, length 0, out_data 0x00, out_valid/out_sof/out_eof/out_err 0 and both counters 0; a frame in progress SHALL be abandoned with no eof, and reception SHALL resume at the next preamble after release.

Configuration
REQ-023 With macro RX_CRC_CHECK_EN defined:
- CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) SHALL run over all DATA bytes including the FCS.
- A residue other than 0xC704DD7B at eof SHALL set out_err.
- Without the macro, no CRC logic SHALL exist and CRC SHALL NOT affect out_err; the FCS is still stripped.

Verification
REQ-024 Valid 64-byte frame after 7x0x55+0xD5 -> 60 bytes out, sof on byte 0, eof on byte 59 with err=0; frames_ok=1; first out_valid 6 cycles after the first DATA byte.
REQ-025 Same frame with rx_er asserted on byte 20 -> 60 bytes out, eof with err=1; frames_bad=1.
REQ-026 (RX_CRC_CHECK_EN) 64-byte frame with one FCS bit flipped -> eof with err=1; without the macro -> err=0.
REQ-027 Preamble 0x55,0x55,0x3C -> no output, no count change; a following valid frame is received normally.
REQ-028 1600-byte frame -> 1514 bytes out, eof err=1 on byte 1513, frames_bad+1, the rest discarded; a 3-byte frame after SFD -> no output, frames_bad+1.
REQ-029 reset_n pulsed low mid-DATA -> outputs 0 at once, no eof; the next valid frame yields frames_ok=1.
